// File: rtl/reglk_ctrl_v2_pkg.sv
// Shared types and constants for the register-lock controller:
// unlock FSM states, control-bit positions and register-map offsets.
package reglk_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_ARM      = 2'd1,
    ST_SCRUB    = 2'd2,
    ST_UNLOCKED = 2'd3
  } fsm_state_e;

  localparam int unsigned CTRL_RD_MASK = 0;
  localparam int unsigned CTRL_WR_LOCK = 1;
  localparam int unsigned CTRL_LM_LOCK = 2;

  function automatic int unsigned lockmask_idx(input int unsigned num_words);
    return num_words;
  endfunction

  function automatic int unsigned status_idx(input int unsigned num_words);
    return num_words + 1;
  endfunction

endpackage

// File: rtl/reglk_ctrl_v2_if.sv
// Valid/ready register request port with a fixed one-cycle response.
interface reglk_ctrl_v2_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reglk_ctrl_v2_unlock_fsm.sv
// JTAG unlock sequencer: debounces the unlock level for UNLOCK_HOLD cycles,
// then walks the scrub index across every data word before unlocking.
module reglk_unlock_fsm
  import reglk_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 6,
  parameter int unsigned UNLOCK_HOLD = 16,
  parameter int unsigned SIDX_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jtag_unlock_i,
  output fsm_state_e        state_o,
  output logic              scrub_en_o,
  output logic [SIDX_W-1:0] scrub_idx_o
);
  localparam int unsigned       CNT_W    = $clog2(UNLOCK_HOLD + 1);
  localparam logic [CNT_W-1:0]  HOLD_M1  = CNT_W'(UNLOCK_HOLD - 1);
  localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(NUM_WORDS - 1);

  fsm_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SIDX_W-1:0] idx_q;

  // The counter holds the number of consecutive high samples seen so far.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (jtag_unlock_i) begin
            state_q <= ST_ARM;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_ARM: begin
          if (!jtag_unlock_i) begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_M1) begin
            state_q <= ST_SCRUB;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SCRUB: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_UNLOCKED;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + SIDX_W'(1);
          end
        end
        ST_UNLOCKED: begin
          if (!jtag_unlock_i) begin
            state_q <= ST_NORMAL;
          end else begin
            state_q <= ST_UNLOCKED;
          end
        end
        default: begin
          state_q <= ST_NORMAL;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign state_o     = state_q;
  assign scrub_en_o  = (state_q == ST_SCRUB);
  assign scrub_idx_o = idx_q;

endmodule

// File: rtl/reglk_ctrl_v2.sv
// Register-lock controller: lock words, sticky LOCKMASK, STATUS and JTAG scrub.
// Optional per-word parity with fail-secure lock output: define REGLK_PARITY_EN.
module reglk_ctrl_v2
  import reglk_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 6,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned UNLOCK_HOLD = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        jtag_unlock_i,
  input  logic [7:0]                  reglk_ctrl_i,
  input  logic                        acct_ctrl_i,
  reglk_ctrl_v2_if.slave              bus,
  output logic [NUM_WORDS*WORD_W-1:0] reglk_ctrl_o,
  output logic                        unlock_active_o
);
  localparam int unsigned       IDX_W  = ADDR_W - 3;
  localparam int unsigned       SIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LM_IDX = IDX_W'(lockmask_idx(NUM_WORDS));
  localparam logic [IDX_W-1:0]  ST_IDX = IDX_W'(status_idx(NUM_WORDS));

  fsm_state_e        state_s;
  logic              scrub_en_s;
  logic [SIDX_W-1:0] scrub_idx_s;

  logic [WORD_W-1:0]    words_q [NUM_WORDS];
  logic [WORD_W-1:0]    words_d [NUM_WORDS];
  logic [NUM_WORDS-1:0] lockmask_q, lockmask_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WORD_W-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic              accept_s, unlocked_s, parity_err_s;
  logic              wr_word_s, wr_lm_s;
  logic [IDX_W-1:0]  idx_s;
  logic              word_hit_s, word_lock_s;
  logic [WORD_W-1:0] word_rd_s;
  logic              unused_s;

  reglk_unlock_fsm #(
    .NUM_WORDS  (NUM_WORDS),
    .UNLOCK_HOLD(UNLOCK_HOLD),
    .SIDX_W     (SIDX_W)
  ) u_unlock_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .jtag_unlock_i(jtag_unlock_i),
    .state_o      (state_s),
    .scrub_en_o   (scrub_en_s),
    .scrub_idx_o  (scrub_idx_s)
  );

  assign bus.req_ready   = (state_s != ST_SCRUB);
  assign accept_s        = bus.req_valid && bus.req_ready;
  assign idx_s           = bus.req_addr[ADDR_W-1:3];
  assign unlocked_s      = (state_s == ST_UNLOCKED);
  assign unlock_active_o = (state_s == ST_SCRUB) || (state_s == ST_UNLOCKED);
  assign unused_s        = ^{bus.req_addr[2:0], reglk_ctrl_i[7:3]};

  // Address decode of the selected data word and its lock bit.
  always_comb begin
    word_hit_s  = 1'b0;
    word_lock_s = 1'b0;
    word_rd_s   = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      word_hit_s  = word_hit_s | (idx_s == IDX_W'(i));
      word_lock_s = word_lock_s | ((idx_s == IDX_W'(i)) & lockmask_q[i]);
      word_rd_s   = word_rd_s | ({WORD_W{idx_s == IDX_W'(i)}} & words_q[i]);
    end
  end

  // Request decode, response generation and storage next-state.
  always_comb begin
    rsp_valid_d = accept_s;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    wr_word_s   = 1'b0;
    wr_lm_s     = 1'b0;
    if (accept_s && bus.req_we) begin
      if (word_hit_s) begin
        if (acct_ctrl_i && !parity_err_s &&
            (unlocked_s || (!reglk_ctrl_i[CTRL_WR_LOCK] && !word_lock_s))) begin
          wr_word_s = 1'b1;
        end else begin
          rsp_err_d = 1'b1;
        end
      end else if (idx_s == LM_IDX) begin
        if (acct_ctrl_i && (unlocked_s || !reglk_ctrl_i[CTRL_LM_LOCK])) begin
          wr_lm_s = 1'b1;
        end else begin
          rsp_err_d = 1'b1;
        end
      end else begin
        rsp_err_d = 1'b1;
      end
    end else if (accept_s) begin
      if (!acct_ctrl_i) begin
        rsp_err_d = 1'b1;
      end else if (idx_s == ST_IDX) begin
        rsp_rdata_d = WORD_W'({parity_err_s, state_s});
      end else if (word_hit_s) begin
        rsp_rdata_d = reglk_ctrl_i[CTRL_RD_MASK] ? '0 : word_rd_s;
      end else if (idx_s == LM_IDX) begin
        rsp_rdata_d = reglk_ctrl_i[CTRL_RD_MASK] ? '0 : WORD_W'(lockmask_q);
      end else begin
        rsp_err_d = 1'b1;
      end
    end else begin
      rsp_err_d = 1'b0;
    end

    // Scrub takes priority; the port is stalled during scrub anyway.
    for (int i = 0; i < NUM_WORDS; i++) begin
      words_d[i] = (scrub_en_s && (scrub_idx_s == SIDX_W'(i))) ? '0 :
                   ((wr_word_s && (idx_s == IDX_W'(i))) ? bus.req_wdata : words_q[i]);
    end
    lockmask_d = (scrub_en_s && (scrub_idx_s == '0)) ? '0 :
                 (wr_lm_s ? (lockmask_q | bus.req_wdata[NUM_WORDS-1:0]) : lockmask_q);
  end

  // Storage and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        words_q[i] <= '0;
      end
      lockmask_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        words_q[i] <= words_d[i];
      end
      lockmask_q  <= lockmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef REGLK_PARITY_EN
  logic [NUM_WORDS-1:0] par_q, par_d;
  logic                 parity_err_q, parity_err_d;

  // Even parity follows every word update; a stored mismatch latches the error.
  always_comb begin
    parity_err_d = parity_err_q;
    for (int i = 0; i < NUM_WORDS; i++) begin
      par_d[i] = (scrub_en_s && (scrub_idx_s == SIDX_W'(i))) ? 1'b0 :
                 ((wr_word_s && (idx_s == IDX_W'(i))) ? ^bus.req_wdata : par_q[i]);
      parity_err_d = parity_err_d | ((^words_q[i]) != par_q[i]);
    end
    parity_err_d = scrub_en_s ? 1'b0 : parity_err_d;
  end

  // Parity storage and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q        <= '0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_s = parity_err_q;
`else
  assign parity_err_s = 1'b0;
`endif

  // Lock vector; a parity fault forces every lock on.
  always_comb begin
    reglk_ctrl_o = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      reglk_ctrl_o[i*WORD_W +: WORD_W] = parity_err_s ? {WORD_W{1'b1}} : words_q[i];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_reglk_ctrl_v2.sv
// Directed scoreboard bench for reglk_ctrl_v2 (default NUM_WORDS=6, UNLOCK_HOLD=16).
module tb_reglk_ctrl_v2;
  localparam int NW = 6;
  localparam int WW = 32;
  localparam int AW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           jtag;
  logic           acct;
  logic [7:0]     ctrl;
  logic [NW*WW-1:0] lock_vec;
  logic           unlock_act;

  reglk_ctrl_v2_if #(.ADDR_W(AW), .WORD_W(WW)) bus_if ();

  reglk_ctrl_v2 #(
    .NUM_WORDS(NW), .WORD_W(WW), .ADDR_W(AW), .UNLOCK_HOLD(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .jtag_unlock_i(jtag), .reglk_ctrl_i(ctrl),
    .acct_ctrl_i(acct), .bus(bus_if), .reglk_ctrl_o(lock_vec),
    .unlock_active_o(unlock_act)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  exp_t  mon_e;
  string mon_tag;
  int    total = 0;
  int    bad = 0;
  int    n;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input string tag, input logic we, input logic [7:0] addr,
                     input logic [31:0] wd, input logic chk_rd,
                     input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    check({tag, "_ready"}, 192'(bus_if.req_ready), 192'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wd;
    e.chk_rd = chk_rd;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    sb.push_back(e);
    sb_tag.push_back(tag);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  // Response monitor: every response pulse pops one scoreboard entry.
  always @(negedge clk) begin
    if (bus_if.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL rsp_unexpected: observed response, expected none");
      end else begin
        mon_e   = sb.pop_front();
        mon_tag = sb_tag.pop_front();
        check({mon_tag, "_err"}, 192'(bus_if.rsp_err), 192'(mon_e.err));
        if (mon_e.chk_rd) check({mon_tag, "_rdata"}, 192'(bus_if.rsp_rdata), 192'(mon_e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; jtag = 1'b0; acct = 1'b1; ctrl = 8'h00;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0;
    bus_if.req_addr = 8'h00; bus_if.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", lock_vec, 192'd0);
    check("rst_unlock", 192'(unlock_act), 192'd0);
    check("rst_rspv", 192'(bus_if.rsp_valid), 192'd0);
    rst = 1'b0;

    req("wr_w1", 1'b1, 8'h08, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0);
    check("vec_w1", 192'(lock_vec[63:32]), 192'h A5A5_0001);
    req("rd_w1", 1'b0, 8'h08, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0);
    req("wr_lm", 1'b1, 8'h30, 32'h2, 1'b0, 32'h0, 1'b0);
    req("rd_lm", 1'b0, 8'h30, 32'h0, 1'b1, 32'h2, 1'b0);
    req("wr_locked", 1'b1, 8'h08, 32'h1234, 1'b0, 32'h0, 1'b1);
    check("vec_locked", 192'(lock_vec[63:32]), 192'h A5A5_0001);
    req("rd_locked", 1'b0, 8'h08, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0);
    req("wr_lm0", 1'b1, 8'h30, 32'h0, 1'b0, 32'h0, 1'b0);
    req("rd_lm_sticky", 1'b0, 8'h30, 32'h0, 1'b1, 32'h2, 1'b0);

    ctrl = 8'h01;
    req("rd_mask_w0", 1'b0, 8'h00, 32'h0, 1'b1, 32'h0, 1'b0);
    req("rd_mask_w1", 1'b0, 8'h08, 32'h0, 1'b1, 32'h0, 1'b0);
    req("rd_status", 1'b0, 8'h38, 32'h0, 1'b1, 32'h0, 1'b0);
    ctrl = 8'h00; acct = 1'b0;
    req("rd_noacct", 1'b0, 8'h00, 32'h0, 1'b1, 32'h0, 1'b1);
    req("wr_noacct", 1'b1, 8'h10, 32'h99, 1'b0, 32'h0, 1'b1);
    acct = 1'b1;
    req("rd_w2_clean", 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 1'b0);
    ctrl = 8'h02;
    req("wr_glock", 1'b1, 8'h10, 32'h77, 1'b0, 32'h0, 1'b1);
    ctrl = 8'h04;
    req("wr_lmlock", 1'b1, 8'h30, 32'h1, 1'b0, 32'h0, 1'b1);
    req("rd_lm_lock", 1'b0, 8'h30, 32'h0, 1'b1, 32'h2, 1'b0);
    ctrl = 8'h00;
    req("wr_w2", 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    req("wr_w5", 1'b1, 8'h28, 32'h5555, 1'b0, 32'h0, 1'b0);
    check("vec_all", lock_vec, {32'h5555, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'hA5A5_0001, 32'h0});
    req("rd_unmapped", 1'b0, 8'h40, 32'h0, 1'b0, 32'h0, 1'b1);
    req("wr_status", 1'b1, 8'h38, 32'h1, 1'b0, 32'h0, 1'b1);
    req("wr_unmapped", 1'b1, 8'h48, 32'h1, 1'b0, 32'h0, 1'b1);

    // 15 high samples, the first coinciding with a write: no scrub.
    jtag = 1'b1;
    req("wr_arm_edge", 1'b1, 8'h18, 32'hC3, 1'b0, 32'h0, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    jtag = 1'b0;
    @(posedge clk);
    #1;
    check("hold15_inactive", 192'(unlock_act), 192'd0);
    req("rd_status_15", 1'b0, 8'h38, 32'h0, 1'b1, 32'h0, 1'b0);
    req("rd_arm_edge", 1'b0, 8'h18, 32'h0, 1'b1, 32'hC3, 1'b0);
    req("rd_w1_kept", 1'b0, 8'h08, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0);

    // 16 high samples: scrub then unlocked.
    jtag = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("scrub_active", 192'(unlock_act), 192'd1);
    check("scrub_notready", 192'(bus_if.req_ready), 192'd0);
    n = 0;
    while (bus_if.req_ready !== 1'b1 && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("scrub_len", 192'(n), 192'd6);
    check("scrub_vec", lock_vec, 192'd0);
    check("unl_active", 192'(unlock_act), 192'd1);
    req("rd_lm_scrub", 1'b0, 8'h30, 32'h0, 1'b1, 32'h0, 1'b0);
    req("rd_status_unl", 1'b0, 8'h38, 32'h0, 1'b1, 32'h3, 1'b0);
    req("wr_lm_unl", 1'b1, 8'h30, 32'h2, 1'b0, 32'h0, 1'b0);
    ctrl = 8'h06;
    req("wr_unl_locked", 1'b1, 8'h08, 32'h1234, 1'b0, 32'h0, 1'b0);
    req("rd_unl", 1'b0, 8'h08, 32'h0, 1'b1, 32'h1234, 1'b0);
    acct = 1'b0;
    req("wr_unl_noacct", 1'b1, 8'h10, 32'h1, 1'b0, 32'h0, 1'b1);
    acct = 1'b1; ctrl = 8'h00;
    @(negedge clk);
    jtag = 1'b0;
    @(posedge clk);
    #1;
    check("unl_exit", 192'(unlock_act), 192'd0);
    req("wr_relocked", 1'b1, 8'h08, 32'h5678, 1'b0, 32'h0, 1'b1);
    req("rd_relocked", 1'b0, 8'h08, 32'h0, 1'b1, 32'h1234, 1'b0);

    // Reset during the third scrub cycle.
    req("wr_w0", 1'b1, 8'h00, 32'hFF, 1'b0, 32'h0, 1'b0);
    req("wr_w5b", 1'b1, 8'h28, 32'h77, 1'b0, 32'h0, 1'b0);
    jtag = 1'b1;
    repeat (16) @(posedge clk);
    repeat (3) @(negedge clk);
    check("mid_scrub_w5", 192'(lock_vec[191:160]), 192'h77);
    check("mid_scrub_active", 192'(unlock_act), 192'd1);
    rst = 1'b1; jtag = 1'b0;
    @(posedge clk);
    #1;
    check("rst_scrub_vec", lock_vec, 192'd0);
    check("rst_scrub_unlock", 192'(unlock_act), 192'd0);
    check("rst_scrub_rspv", 192'(bus_if.rsp_valid), 192'd0);
    rst = 1'b0;
    req("rd_status_rst", 1'b0, 8'h38, 32'h0, 1'b1, 32'h0, 1'b0);
    req("rd_lm_rst", 1'b0, 8'h30, 32'h0, 1'b1, 32'h0, 1'b0);

`ifdef REGLK_PARITY_EN
    req("wr_par", 1'b1, 8'h08, 32'h1, 1'b0, 32'h0, 1'b0);
    force dut.words_q[1] = 32'h3;
    @(posedge clk);
    #1;
    release dut.words_q[1];
    @(posedge clk);
    #1;
    check("par_vec", lock_vec, {192{1'b1}});
    req("rd_status_par", 1'b0, 8'h38, 32'h0, 1'b1, 32'h4, 1'b0);
    req("wr_par_err", 1'b1, 8'h10, 32'h1, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("par_rst_vec", lock_vec, 192'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 192'(sb.size()), 192'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
